// File: rtl/frame_buffer_writer_if.sv
// Processed pixel stream between the scaling datapath (master) and the frame buffer writer (slave).
interface frame_buffer_writer_if #(
  parameter int PIX_W = 8
) ();
  logic [PIX_W-1:0] pixel_in;
  logic             pixel_valid;
  logic             pixel_ready;

  modport master (output pixel_in, output pixel_valid, input pixel_ready);
  modport slave  (input pixel_in, input pixel_valid, output pixel_ready);
endinterface

// File: rtl/frame_buffer_writer.sv
// Raster-order writer into a double-buffered frame RAM; a finished bank is handed to scan-out on vsync.
// Optional FBW_STATS_EN adds a 16-bit frame_count output counting completed swaps.
module frame_buffer_writer #(
  parameter int MAX_W  = 640,
  parameter int MAX_H  = 480,
  parameter int ADDR_W = 20,
  parameter int PIX_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [9:0]            out_w,
  input  logic [8:0]            out_h,
  frame_buffer_writer_if.slave  pix,
  input  logic                  vsync_pulse,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [PIX_W-1:0]      wr_data,
  output logic                  display_bank,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_cfg,
`ifdef FBW_STATS_EN
  output logic                  err_drop,
  output logic [15:0]           frame_count
`else
  output logic                  err_drop
`endif
);

  localparam logic [9:0]        MAX_W_V   = 10'(MAX_W);
  localparam logic [8:0]        MAX_H_V   = 9'(MAX_H);
  localparam logic [ADDR_W-1:0] BANK_BASE = ADDR_W'(MAX_W * MAX_H);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CAPTURE   = 2'd1,
    S_WAIT_SWAP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_ready;
  logic                w_busy;

  logic [9:0]          r_w;
  logic [8:0]          r_h;
  logic [9:0]          r_x;
  logic [8:0]          r_y;
  logic [ADDR_W-1:0]   r_lin;
  logic                r_wr_bank;
  logic                r_display_bank;
  logic                r_frame_done;
  logic                r_err_cfg;
  logic                r_err_drop;
  logic                r_vld_p1;
  logic [ADDR_W-1:0]   r_addr_p1;
  logic [PIX_W-1:0]    r_data_p1;
`ifdef FBW_STATS_EN
  logic [15:0]         r_frame_count;
`endif

  logic                w_cfg_ok;
  logic                w_beat;
  logic                w_x_end;
  logic                w_last;
  logic                w_drop;
  logic [ADDR_W-1:0]   w_base;

  assign w_cfg_ok = (out_w != 10'd0) && (out_w <= MAX_W_V) &&
                    (out_h != 9'd0)  && (out_h <= MAX_H_V);
  assign w_beat   = pix.pixel_valid && w_ready;
  assign w_x_end  = (r_x == r_w - 10'd1);
  assign w_last   = w_x_end && (r_y == r_h - 9'd1);
  assign w_drop   = pix.pixel_valid && !w_ready;
  assign w_base   = r_wr_bank ? BANK_BASE : '0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start && w_cfg_ok)  w_next = S_CAPTURE;
      S_CAPTURE:   if (w_beat && w_last)   w_next = S_WAIT_SWAP;
      S_WAIT_SWAP: if (vsync_pulse)        w_next = S_IDLE;
      default:                             w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b1;
    case (r_state)
      S_IDLE:    w_busy  = 1'b0;
      S_CAPTURE: w_ready = 1'b1;
      default:   ;
    endcase
  end

  // Stage p0 -> p1: accepted beat becomes a registered RAM write one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w            <= '0;
      r_h            <= '0;
      r_x            <= '0;
      r_y            <= '0;
      r_lin          <= '0;
      r_wr_bank      <= 1'b0;
      r_display_bank <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_cfg      <= 1'b0;
      r_err_drop     <= 1'b0;
      r_vld_p1       <= 1'b0;
      r_addr_p1      <= '0;
      r_data_p1      <= '0;
`ifdef FBW_STATS_EN
      r_frame_count  <= '0;
`endif
    end else begin
      r_vld_p1     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_w        <= out_w;
              r_h        <= out_h;
              r_x        <= '0;
              r_y        <= '0;
              r_lin      <= '0;
              r_wr_bank  <= ~r_display_bank;
              r_err_cfg  <= 1'b0;
              r_err_drop <= 1'b0;
            end else begin
              r_err_cfg  <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (w_beat) begin
            r_vld_p1  <= 1'b1;
            r_addr_p1 <= w_base + r_lin;
            r_data_p1 <= pix.pixel_in;
            r_lin     <= r_lin + ADDR_W'(1);
            if (w_x_end) begin
              r_x <= '0;
              r_y <= r_y + 9'd1;
            end else begin
              r_x <= r_x + 10'd1;
            end
          end
        end
        S_WAIT_SWAP: begin
          // Only here may the scan-out bank change, so a half-written bank is never shown
          if (vsync_pulse) begin
            r_display_bank <= r_wr_bank;
            r_frame_done   <= 1'b1;
`ifdef FBW_STATS_EN
            r_frame_count  <= r_frame_count + 16'd1;
`endif
          end
        end
        default: ;
      endcase
      // A pixel offered while not ready is lost; flag it even on a clearing start
      if (w_drop) r_err_drop <= 1'b1;
    end
  end

  assign pix.pixel_ready = w_ready;
  assign busy            = w_busy;
  assign wr_en           = r_vld_p1;
  assign wr_addr         = r_addr_p1;
  assign wr_data         = r_data_p1;
  assign display_bank    = r_display_bank;
  assign frame_done      = r_frame_done;
  assign err_cfg         = r_err_cfg;
  assign err_drop        = r_err_drop;
`ifdef FBW_STATS_EN
  assign frame_count     = r_frame_count;
`endif

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer with an 8x4 frame (bank size 32); covers FBW_STATS_EN when defined.
module tb_frame_buffer_writer;
  localparam int MAX_W  = 8;
  localparam int MAX_H  = 4;
  localparam int ADDR_W = 6;
  localparam int PIX_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              vsync = 1'b0;
  logic [9:0]        out_w = '0;
  logic [8:0]        out_h = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              display_bank, busy, frame_done, err_cfg, err_drop;
`ifdef FBW_STATS_EN
  logic [15:0]       frame_count;
`endif

  frame_buffer_writer_if #(.PIX_W(PIX_W)) pix ();

  frame_buffer_writer #(
    .MAX_W(MAX_W), .MAX_H(MAX_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .out_w(out_w), .out_h(out_h),
    .pix(pix), .vsync_pulse(vsync),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .display_bank(display_bank), .busy(busy), .frame_done(frame_done),
    .err_cfg(err_cfg),
`ifdef FBW_STATS_EN
    .err_drop(err_drop), .frame_count(frame_count)
`else
    .err_drop(err_drop)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int n_wr  = 0;
  int wr0;

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en === 1'b1) n_wr++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int w, input int h);
    out_w = 10'(w);
    out_h = 9'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int n, input int base, input int d0);
    for (int i = 0; i < n; i++) begin
      pix.pixel_valid = 1'b1;
      pix.pixel_in    = 8'(d0 + i);
      tick();
      chk($sformatf("wr_en[%0d]", i),   32'(wr_en),   32'd1);
      chk($sformatf("wr_addr[%0d]", i), 32'(wr_addr), 32'(base + i));
      chk($sformatf("wr_data[%0d]", i), 32'(wr_data), 32'(d0 + i));
    end
    pix.pixel_valid = 1'b0;
  endtask

  task automatic swap(input int exp_bank);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("swap_bank", 32'(display_bank), 32'(exp_bank));
    chk("swap_done", 32'(frame_done), 32'd1);
    chk("swap_busy", 32'(busy), 32'd0);
    tick();
    chk("done_pulse", 32'(frame_done), 32'd0);
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_busy"},  32'(busy), 32'd0);
    chk({pfx, "_ready"}, 32'(pix.pixel_ready), 32'd0);
    chk({pfx, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({pfx, "_addr"},  32'(wr_addr), 32'd0);
    chk({pfx, "_data"},  32'(wr_data), 32'd0);
    chk({pfx, "_bank"},  32'(display_bank), 32'd0);
    chk({pfx, "_done"},  32'(frame_done), 32'd0);
    chk({pfx, "_ecfg"},  32'(err_cfg), 32'd0);
    chk({pfx, "_edrop"}, 32'(err_drop), 32'd0);
`ifdef FBW_STATS_EN
    chk({pfx, "_fcnt"},  32'(frame_count), 32'd0);
`endif
  endtask

  initial begin
    pix.pixel_valid = 1'b0;
    pix.pixel_in    = '0;
    tick();
    tick();
    chk_reset_state("rst");
    rst = 1'b0;

    // frame 1: 4x2 into bank 1
    do_start(4, 2);
    chk("f1_busy", 32'(busy), 32'd1);
    chk("f1_ready", 32'(pix.pixel_ready), 32'd1);
    stream(8, 32, 8'h10);
    chk("f1_ready_low", 32'(pix.pixel_ready), 32'd0);
    chk("f1_bank_hold", 32'(display_bank), 32'd0);
    tick();
    chk("f1_no_wr", 32'(wr_en), 32'd0);
    swap(1);

    // frame 2: 4x2 into bank 0
    do_start(4, 2);
    stream(8, 0, 8'h40);
    swap(0);
`ifdef FBW_STATS_EN
    chk("fcnt2", 32'(frame_count), 32'd2);
`endif

    // rejected configurations
    wr0 = n_wr;
    do_start(0, 2);
    chk("cfg_w0_err", 32'(err_cfg), 32'd1);
    chk("cfg_w0_busy", 32'(busy), 32'd0);
    do_start(9, 2);
    chk("cfg_w9_err", 32'(err_cfg), 32'd1);
    chk("cfg_w9_busy", 32'(busy), 32'd0);
    tick();
    chk("cfg_no_wr", 32'(n_wr - wr0), 32'd0);

    // valid 2x2 clears err_cfg; gapped valid, vsync coincident with last beat
    do_start(2, 2);
    chk("cfg_ok_err", 32'(err_cfg), 32'd0);
    chk("cfg_ok_busy", 32'(busy), 32'd1);
    wr0 = n_wr;
    for (int i = 0; i < 4; i++) begin
      pix.pixel_valid = 1'b1;
      pix.pixel_in    = 8'(8'hA0 + i);
      vsync = (i == 3);
      tick();
      pix.pixel_valid = 1'b0;
      vsync = 1'b0;
      chk($sformatf("gap_addr[%0d]", i), 32'(wr_addr), 32'(32 + i));
      chk($sformatf("gap_data[%0d]", i), 32'(wr_data), 32'(8'hA0 + i));
      tick();
      chk($sformatf("gap_idle[%0d]", i), 32'(wr_en), 32'd0);
      tick();
    end
    chk("gap_count", 32'(n_wr - wr0), 32'd4);
    chk("gap_noswap", 32'(display_bank), 32'd0);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_ready", 32'(pix.pixel_ready), 32'd0);

    // pixel during WAIT_SWAP is dropped; start while busy is ignored
    wr0 = n_wr;
    pix.pixel_valid = 1'b1;
    pix.pixel_in    = 8'hEE;
    tick();
    pix.pixel_valid = 1'b0;
    chk("drop_err", 32'(err_drop), 32'd1);
    tick();
    chk("drop_no_wr", 32'(n_wr - wr0), 32'd0);
    do_start(3, 3);
    chk("busy_start_busy", 32'(busy), 32'd1);
    chk("busy_start_ready", 32'(pix.pixel_ready), 32'd0);
    chk("busy_start_ecfg", 32'(err_cfg), 32'd0);
    swap(1);
    chk("drop_sticky", 32'(err_drop), 32'd1);
`ifdef FBW_STATS_EN
    chk("fcnt3", 32'(frame_count), 32'd3);
`endif

    // reset in the middle of a capture
    do_start(4, 2);
    chk("clr_drop", 32'(err_drop), 32'd0);
    stream(3, 0, 8'h60);
    rst = 1'b1;
    tick();
    chk_reset_state("mid_rst");
    rst = 1'b0;
    do_start(4, 2);
    stream(8, 32, 8'h80);
    swap(1);
`ifdef FBW_STATS_EN
    chk("fcnt_after_rst", 32'(frame_count), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
